clause_array_ctrl: RTL

CLAUSE_ARRAY_CTRL -- requirements
Module: clause_array_ctrl

---
 rtl/sat_ctrl_pkg.sv | 25 ++
 rtl/prio_enc_lowest.sv | 23 ++
 rtl/clause_array_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sat_ctrl_pkg.sv
// Shared definitions for the clause-array controller: FSM state encoding and a
// constant-safe ceil(log2) helper used to size counters and index ports.
package sat_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRV   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_CONFL = 3'd4,
    ST_BKT   = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  // Never returns 0 so that derived vector widths stay legal for tiny parameters.
  function automatic int unsigned clog2_f(input int unsigned n);
    int unsigned r;
    r = 32'd0;
    for (int unsigned i = 32'd0; i < 32'd32; i++) begin
      r = (({32'd0, 32'd1} << i) < {32'd0, n}) ? (i + 32'd1) : r;
    end
    return (r == 32'd0) ? 32'd1 : r;
  endfunction

endpackage

// File: rtl/prio_enc_lowest.sv
// Lowest-set-bit priority encoder: returns the index of the lowest asserted
// bit of vec_i and flags whether any bit was set at all.
module prio_enc_lowest
  import sat_ctrl_pkg::*;
#(
  parameter int unsigned N = 8,
  localparam int unsigned IW = clog2_f(N)
) (
  input  logic [N-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx_o   = '0;
    valid_o = |vec_i;
    for (int i = N - 1; i >= 0; i--) begin
      idx_o = vec_i[i] ? IW'(i) : idx_o;
    end
  end

endmodule

// File: rtl/clause_array_ctrl.sv
// Sequencer for a clause-array SAT accelerator: row loading, iterated boolean
// constraint propagation with conflict detection, and backtrack application.
module clause_array_ctrl
  import sat_ctrl_pkg::*;
#(
  parameter int unsigned NUM_C     = 8,
  parameter int unsigned WIDTH_LVL = 16,
  parameter int unsigned MAX_ITER  = 255,
  localparam int unsigned IDXW     = clog2_f(NUM_C)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start_i,
  input  logic                 load_valid_i,
  output logic                 load_ready_o,
  output logic [NUM_C-1:0]     wr_o,
  input  logic                 bcp_start_i,
  output logic                 imp_drv_o,
  input  logic                 var_changed_i,
  input  logic [NUM_C-1:0]     cclause_i,
  output logic [NUM_C-1:0]     cclause_drv_o,
  input  logic                 bkt_start_i,
  input  logic [WIDTH_LVL-1:0] bkt_lvl_i,
  output logic                 apply_bkt_o,
  output logic [WIDTH_LVL-1:0] bkt_lvl_o,
  output logic                 done_o,
  output logic                 conflict_o,
  output logic                 timeout_o,
  output logic [IDXW-1:0]      conflict_idx_o,
  output logic                 busy_o
);

  localparam int unsigned ITW = clog2_f(MAX_ITER + 32'd1);
  localparam logic [ITW-1:0]   MAX_ITER_C = ITW'(MAX_ITER);
  localparam logic [IDXW-1:0]  LAST_ROW_C = IDXW'(NUM_C - 32'd1);
  localparam logic [NUM_C-1:0] ONE_C      = NUM_C'(1'b1);

  state_e               state_q, state_d;
  logic [IDXW-1:0]      row_q, row_d;
  logic [ITW-1:0]       iter_q, iter_d;
  logic [IDXW-1:0]      cidx_q, cidx_d;
  logic                 conflict_q, conflict_d;
  logic                 timeout_q, timeout_d;
  logic [WIDTH_LVL-1:0] bkt_lvl_q, bkt_lvl_d;

  logic [IDXW-1:0]      enc_idx;
  logic                 enc_valid;

  prio_enc_lowest #(
    .N (NUM_C)
  ) u_prio_enc (
    .vec_i   (cclause_i),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      iter_q     <= '0;
      cidx_q     <= '0;
      conflict_q <= 1'b0;
      timeout_q  <= 1'b0;
      bkt_lvl_q  <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      iter_q     <= iter_d;
      cidx_q     <= cidx_d;
      conflict_q <= conflict_d;
      timeout_q  <= timeout_d;
      bkt_lvl_q  <= bkt_lvl_d;
    end
  end

  // Next-state logic and per-state strobes; strobes come only from distinct
  // states, which keeps the array drives mutually exclusive by construction.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    iter_d        = iter_q;
    cidx_d        = cidx_q;
    conflict_d    = conflict_q;
    timeout_d     = timeout_q;
    bkt_lvl_d     = bkt_lvl_q;
    load_ready_o  = 1'b0;
    wr_o          = '0;
    imp_drv_o     = 1'b0;
    cclause_drv_o = '0;
    apply_bkt_o   = 1'b0;
    done_o        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bkt_start_i) begin
          state_d    = ST_BKT;
          bkt_lvl_d  = bkt_lvl_i;
          conflict_d = 1'b0;
          timeout_d  = 1'b0;
          cidx_d     = '0;
        end else if (load_start_i) begin
          state_d    = ST_LOAD;
          row_d      = '0;
          conflict_d = 1'b0;
          timeout_d  = 1'b0;
          cidx_d     = '0;
        end else if (bcp_start_i) begin
          state_d    = ST_DRV;
          iter_d     = '0;
          conflict_d = 1'b0;
          timeout_d  = 1'b0;
          cidx_d     = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        load_ready_o = 1'b1;
        if (load_valid_i) begin
          wr_o = ONE_C << row_q;
          if (row_q == LAST_ROW_C) begin
            row_d   = '0;
            state_d = ST_DONE;
          end else begin
            row_d = row_q + IDXW'(1'b1);
          end
        end else begin
          row_d = row_q;
        end
      end
      ST_DRV: begin
        imp_drv_o = 1'b1;
        iter_d    = (iter_q == MAX_ITER_C) ? iter_q : iter_q + ITW'(1'b1);
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (enc_valid) begin
          cidx_d     = enc_idx;
          conflict_d = 1'b1;
          state_d    = ST_CONFL;
        end else if (var_changed_i) begin
          if (iter_q == MAX_ITER_C) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_DRV;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_CONFL: begin
        cclause_drv_o = ONE_C << cidx_q;
        state_d       = ST_DONE;
      end
      ST_BKT: begin
        apply_bkt_o = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_o         = (state_q != ST_IDLE);
  assign bkt_lvl_o      = bkt_lvl_q;
  assign conflict_o     = conflict_q;
  assign timeout_o      = timeout_q;
  assign conflict_idx_o = cidx_q;

endmodule
